// File: rtl/multi_priority_pkg.sv
// Shared definitions for the multi-lane priority scanner: FSM encoding and
// a constant-evaluable ceil(log2) used to size index and count fields.
package multi_priority_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = ((32'sd1 <<< i) < value) ? (i + 1) : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/priority_pick.sv
// Combinational single-bit priority picker: reports the winning set bit and
// hands on the input vector with that bit cleared, so instances can be chained.
module priority_pick
    import multi_priority_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [WIDTH-1:0]        vec_i,
    output logic [clog2(WIDTH)-1:0] idx_o,
    output logic                    found_o,
    output logic [WIDTH-1:0]        masked_o
);

    localparam int IDX_W = clog2(WIDTH);

    // Scan toward the priority end so the last hit seen is the winner.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                idx_o   = vec_i[i] ? IDX_W'(i) : idx_o;
                found_o = found_o | vec_i[i];
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                idx_o   = vec_i[i] ? IDX_W'(i) : idx_o;
                found_o = found_o | vec_i[i];
            end
        end
        masked_o = vec_i & ~(WIDTH'(found_o) << idx_o);
    end

endmodule

// File: rtl/multi_priority_scanner.sv
// Accepts a request vector and streams the positions of its set bits in
// priority order, LANES per beat, with a valid/ready handshake on both sides.
module multi_priority_scanner
    import multi_priority_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int LANES     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_req,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*clog2(WIDTH)-1:0]   out_idx,
    output logic [LANES-1:0]                out_lane_vld,
    output logic                            out_last,
    output logic [clog2(WIDTH+1)-1:0]       req_count,
    output logic                            busy
);

    localparam int IDX_W = clog2(WIDTH);
    localparam int CNT_W = clog2(WIDTH + 1);

    state_t                      state_q;
    state_t                      state_d;
    logic [WIDTH-1:0]            pending_q;
    logic [CNT_W-1:0]            req_count_q;
    logic [CNT_W-1:0]            popcnt_s;
    logic [LANES:0][WIDTH-1:0]   lane_vec_s;
    logic [LANES-1:0][IDX_W-1:0] lane_idx_s;
    logic [LANES-1:0]            lane_found_s;
    logic                        last_s;
    logic                        scan_s;

    assign lane_vec_s[0] = pending_q;

    // Each lane picks from what the previous lanes left behind.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        priority_pick #(
            .WIDTH     (WIDTH),
            .MSB_FIRST (MSB_FIRST)
        ) u_pick (
            .vec_i    (lane_vec_s[k]),
            .idx_o    (lane_idx_s[k]),
            .found_o  (lane_found_s[k]),
            .masked_o (lane_vec_s[k+1])
        );
    end

    assign last_s = (lane_vec_s[LANES] == '0);

    // Population count of the incoming vector, latched on accept.
    always_comb begin
        popcnt_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcnt_s = popcnt_s + CNT_W'(in_req[i]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (out_ready && last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; beat contents depend only on registered state.
    always_comb begin
        scan_s       = (state_q == ST_SCAN);
        in_ready     = !scan_s;
        out_valid    = scan_s;
        busy         = scan_s;
        out_last     = scan_s & last_s;
        req_count    = req_count_q;
        out_idx      = '0;
        out_lane_vld = '0;
        for (int k = 0; k < LANES; k++) begin
            out_lane_vld[k]               = scan_s & lane_found_s[k];
            out_idx[k*IDX_W +: IDX_W]     = (scan_s && lane_found_s[k]) ? lane_idx_s[k] : '0;
        end
    end

    // Pending bits and request count; emitted bits drop out on each accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= '0;
            req_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        pending_q   <= in_req;
                        req_count_q <= popcnt_s;
                    end else begin
                        pending_q   <= pending_q;
                        req_count_q <= req_count_q;
                    end
                end
                ST_SCAN: begin
                    if (out_ready) begin
                        pending_q <= lane_vec_s[LANES];
                    end else begin
                        pending_q <= pending_q;
                    end
                end
                default: begin
                    pending_q   <= '0;
                    req_count_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_priority_scanner.sv
// Directed bench: a per-cycle vector table on the default configuration plus
// short hand sequences for LSB-first, single-lane and mid-scan reset.
module tb_multi_priority_scanner;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Instance A: WIDTH=12 LANES=2 MSB_FIRST=1
    logic        a_iv, a_ir, a_ov, a_ordy, a_last, a_busy;
    logic [11:0] a_req;
    logic [7:0]  a_idx;
    logic [1:0]  a_vld;
    logic [3:0]  a_cnt;

    // Instance B: WIDTH=12 LANES=2 MSB_FIRST=0
    logic        b_iv, b_ir, b_ov, b_ordy, b_last, b_busy;
    logic [11:0] b_req;
    logic [7:0]  b_idx;
    logic [1:0]  b_vld;
    logic [3:0]  b_cnt;

    // Instance C: WIDTH=16 LANES=1 MSB_FIRST=1
    logic        c_iv, c_ir, c_ov, c_ordy, c_last, c_busy;
    logic [15:0] c_req;
    logic [3:0]  c_idx;
    logic [0:0]  c_vld;
    logic [4:0]  c_cnt;

    multi_priority_scanner #(.WIDTH(12), .LANES(2), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_iv), .in_ready(a_ir), .in_req(a_req),
        .out_valid(a_ov), .out_ready(a_ordy), .out_idx(a_idx), .out_lane_vld(a_vld),
        .out_last(a_last), .req_count(a_cnt), .busy(a_busy));

    multi_priority_scanner #(.WIDTH(12), .LANES(2), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_iv), .in_ready(b_ir), .in_req(b_req),
        .out_valid(b_ov), .out_ready(b_ordy), .out_idx(b_idx), .out_lane_vld(b_vld),
        .out_last(b_last), .req_count(b_cnt), .busy(b_busy));

    multi_priority_scanner #(.WIDTH(16), .LANES(1), .MSB_FIRST(1'b1)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .in_valid(c_iv), .in_ready(c_ir), .in_req(c_req),
        .out_valid(c_ov), .out_ready(c_ordy), .out_idx(c_idx), .out_lane_vld(c_vld),
        .out_last(c_last), .req_count(c_cnt), .busy(c_busy));

    typedef struct {
        logic        iv;
        logic [11:0] req;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic [7:0]  idx;
        logic [1:0]  vld;
        logic        last;
        logic [3:0]  cnt;
    } row_t;

    row_t rows [15];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // {ov, ir, busy, last, vld, idx, cnt}
    function automatic logic [31:0] pack_a(input logic ov, input logic ir, input logic bsy,
                                           input logic lst, input logic [1:0] vld,
                                           input logic [7:0] idx, input logic [3:0] cnt);
        return {14'd0, ov, ir, bsy, lst, vld, idx, cnt};
    endfunction

    initial begin
        rows[0]  = '{1'b1, 12'hA05, 1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 4'd0};
        rows[1]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h9B, 2'b11, 1'b0, 4'd4};
        rows[2]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h02, 2'b11, 1'b1, 4'd4};
        rows[3]  = '{1'b1, 12'h111, 1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 4'd4};
        rows[4]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h48, 2'b11, 1'b0, 4'd3};
        rows[5]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 4'd3};
        rows[6]  = '{1'b1, 12'h000, 1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 4'd3};
        rows[7]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 4'd0};
        rows[8]  = '{1'b1, 12'hA05, 1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 4'd0};
        rows[9]  = '{1'b1, 12'h111, 1'b0, 1'b1, 1'b0, 8'h9B, 2'b11, 1'b0, 4'd4};
        rows[10] = '{1'b1, 12'h111, 1'b0, 1'b1, 1'b0, 8'h9B, 2'b11, 1'b0, 4'd4};
        rows[11] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'h9B, 2'b11, 1'b0, 4'd4};
        rows[12] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h9B, 2'b11, 1'b0, 4'd4};
        rows[13] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h02, 2'b11, 1'b1, 4'd4};
        rows[14] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 4'd4};

        reset_n = 1'b0;
        a_iv = 1'b0; a_req = 12'h000; a_ordy = 1'b0;
        b_iv = 1'b0; b_req = 12'h000; b_ordy = 1'b0;
        c_iv = 1'b0; c_req = 16'h0000; c_ordy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_a", pack_a(a_ov, a_ir, a_busy, a_last, a_vld, a_idx, a_cnt),
              pack_a(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 4'd0));
        reset_n = 1'b1;
        @(negedge clk);

        // Table: inputs applied and outputs checked mid-cycle, one row per clock.
        for (int r = 0; r < 15; r++) begin
            a_iv   = rows[r].iv;
            a_req  = rows[r].req;
            a_ordy = rows[r].ordy;
            check($sformatf("row%0d", r), pack_a(a_ov, a_ir, a_busy, a_last, a_vld, a_idx, a_cnt),
                  pack_a(rows[r].ov, rows[r].ir, rows[r].ov, rows[r].last, rows[r].vld,
                         rows[r].idx, rows[r].cnt));
            @(negedge clk);
        end
        a_iv = 1'b0;

        // LSB-first on B and single-lane 16-bit on C, started together.
        b_iv = 1'b1; b_req = 12'hA05; b_ordy = 1'b1;
        c_iv = 1'b1; c_req = 16'h8001; c_ordy = 1'b1;
        @(negedge clk);
        b_iv = 1'b0; c_iv = 1'b0;
        check("lsb_beat1", {19'd0, b_ov, b_last, b_vld, b_idx, b_cnt}, {19'd0, 1'b1, 1'b0, 2'b11, 8'h20, 4'd4});
        check("lane1_beat1", {22'd0, c_ov, c_last, c_vld, c_idx, c_cnt}, {22'd0, 1'b1, 1'b0, 1'b1, 4'hF, 5'd2});
        @(negedge clk);
        check("lsb_beat2", {19'd0, b_ov, b_last, b_vld, b_idx, b_cnt}, {19'd0, 1'b1, 1'b1, 2'b11, 8'hB9, 4'd4});
        check("lane1_beat2", {22'd0, c_ov, c_last, c_vld, c_idx, c_cnt}, {22'd0, 1'b1, 1'b1, 1'b1, 4'h0, 5'd2});
        @(negedge clk);
        check("lsb_idle", {30'd0, b_ov, b_ir}, {30'd0, 1'b0, 1'b1});
        check("lane1_idle", {30'd0, c_ov, c_ir}, {30'd0, 1'b0, 1'b1});

        // Asynchronous reset in the middle of a scan.
        a_iv = 1'b1; a_req = 12'hFFF; a_ordy = 1'b0;
        @(negedge clk);
        a_iv = 1'b0;
        check("pre_reset_beat", pack_a(a_ov, a_ir, a_busy, a_last, a_vld, a_idx, a_cnt),
              pack_a(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 8'hAB, 4'd12));
        #1 reset_n = 1'b0;
        #1;
        check("async_reset", pack_a(a_ov, a_ir, a_busy, a_last, a_vld, a_idx, a_cnt),
              pack_a(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 4'd0));
        @(negedge clk);
        reset_n = 1'b1;
        a_iv = 1'b1; a_req = 12'h002; a_ordy = 1'b1;
        @(negedge clk);
        a_iv = 1'b0;
        check("post_reset_beat", pack_a(a_ov, a_ir, a_busy, a_last, a_vld, a_idx, a_cnt),
              pack_a(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 8'h01, 4'd1));
        @(negedge clk);
        check("post_reset_idle", pack_a(a_ov, a_ir, a_busy, a_last, a_vld, a_idx, a_cnt),
              pack_a(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 4'd1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
